// File: rtl/vga_sprite_engine.sv
// Bouncing square sprite over a blue background; one-dclk registered pixel/sync pipeline.
// Optional 2-pixel white screen border compiled in with `define SCREEN_BORDER_EN.
module vga_sprite_engine #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  input  logic       frame_start,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [2:0] red,
  output logic [2:0] green,
  output logic [1:0] blue,
  output logic       hsync,
  output logic       vsync
);

  localparam logic [10:0] X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic [10:0] Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
  localparam logic [10:0] STEP11 = 11'(STEP);
  localparam logic [10:0] BOX11  = 11'(BOX_SIZE);

  localparam logic [7:0] COL_YELLOW = 8'b111_111_00;
  localparam logic [7:0] COL_BLUE   = 8'b000_000_11;

  logic [9:0]  x, y;
  logic        dx, dy;
  logic [10:0] x_step, y_step;
  logic [10:0] hc11, vc11, x11, y11;
  logic        in_sprite;
  logic [7:0]  pix;

  // Returns {new_dir, new_pos}; 11-bit math keeps the bounds check free of wrap-around.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                            input logic [10:0] lim);
    logic [10:0] p;
    p = {1'b0, pos};
    if (!dir) begin
      if (p + STEP11 >= lim) return {1'b1, lim[9:0]};
      else                   return {1'b0, 10'(p + STEP11)};
    end else begin
      if (p <= STEP11) return {1'b0, 10'd0};
      else             return {1'b1, 10'(p - STEP11)};
    end
  endfunction

  assign x_step = step_axis(x, dx, X_MAX);
  assign y_step = step_axis(y, dy, Y_MAX);

  assign hc11 = {1'b0, hcount};
  assign vc11 = {1'b0, vcount};
  assign x11  = {1'b0, x};
  assign y11  = {1'b0, y};

  assign in_sprite = (hc11 >= x11) && (hc11 < x11 + BOX11) &&
                     (vc11 >= y11) && (vc11 < y11 + BOX11);

`ifdef SCREEN_BORDER_EN
  localparam logic [7:0]  COL_WHITE = 8'b111_111_11;
  localparam logic [10:0] H_EDGE    = 11'(H_ACTIVE - 2);
  localparam logic [10:0] V_EDGE    = 11'(V_ACTIVE - 2);
  logic on_border;
  assign on_border = (hc11 < 11'd2) || (hc11 >= H_EDGE) ||
                     (vc11 < 11'd2) || (vc11 >= V_EDGE);
`endif

  always_comb begin
    pix = 8'b0;
    if (!video_on)      pix = 8'b0;
    else if (in_sprite) pix = COL_YELLOW;
`ifdef SCREEN_BORDER_EN
    else if (on_border) pix = COL_WHITE;
`endif
    else                pix = COL_BLUE;
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      x     <= 10'd0;
      y     <= 10'd0;
      dx    <= 1'b0;
      dy    <= 1'b0;
      red   <= 3'd0;
      green <= 3'd0;
      blue  <= 2'd0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else begin
      {red, green, blue} <= pix;
      hsync <= hsync_in;
      vsync <= vsync_in;
      // frame_start arrives in blanking, so a whole frame is drawn from one position.
      if (frame_start && !pause) begin
        {dx, x} <= x_step;
        {dy, y} <= y_step;
      end
    end
  end

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Directed bench for vga_sprite_engine: vector table plus motion/bounce/priority sequences.
module tb_vga_sprite_engine;

  logic       dclk = 1'b0;
  logic       clr, video_on, frame_start, hsync_in, vsync_in, pause;
  logic [9:0] hcount, vcount;
  logic [2:0] red, green;
  logic [1:0] blue;
  logic       hsync, vsync;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [7:0] YEL = 8'b111_111_00;
  localparam logic [7:0] BG  = 8'b000_000_11;
  localparam logic [7:0] BLK = 8'b000_000_00;
`ifdef SCREEN_BORDER_EN
  localparam logic [7:0] BRD = 8'b111_111_11;
`else
  localparam logic [7:0] BRD = BG;
`endif

  vga_sprite_engine dut (
    .dclk(dclk), .clr(clr), .hcount(hcount), .vcount(vcount), .video_on(video_on),
    .frame_start(frame_start), .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .red(red), .green(green), .blue(blue), .hsync(hsync), .vsync(vsync)
  );

  always #20 dclk = ~dclk;

  typedef struct {
    string      name;
    logic       clr;
    logic       von;
    logic       hs;
    logic       vs;
    logic [9:0] hc;
    logic [9:0] vc;
    logic [7:0] rgb;
    logic       ehs;
    logic       evs;
  } vec_t;

  vec_t vecs[$];

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got rgb/hs/vs=%b expected %b", name, act, exp);
    end
  endtask

  task automatic probe(input string name, input logic [9:0] hc, input logic [9:0] vc,
                       input logic [7:0] exp_rgb);
    clr = 1'b0; frame_start = 1'b0; pause = 1'b0;
    video_on = 1'b1; hsync_in = 1'b1; vsync_in = 1'b1;
    hcount = hc; vcount = vc;
    tick();
    check(name, {red, green, blue, hsync, vsync}, {exp_rgb, 2'b11});
  endtask

  task automatic pulse(input logic p);
    clr = 1'b0; video_on = 1'b0; frame_start = 1'b1; pause = p;
    tick();
    frame_start = 1'b0; pause = 1'b0;
  endtask

  function automatic vec_t mk(input string nm, input logic c, input logic v,
                              input logic hs, input logic vs, input int hc, input int vc,
                              input logic [7:0] rgb, input logic ehs, input logic evs);
    vec_t t;
    t.name = nm; t.clr = c; t.von = v; t.hs = hs; t.vs = vs;
    t.hc = 10'(hc); t.vc = 10'(vc); t.rgb = rgb; t.ehs = ehs; t.evs = evs;
    return t;
  endfunction

  initial begin
    // Sprite at (0,0) after reset.
    vecs.push_back(mk("sprite_origin",   0, 1, 1, 1,   0,   0, YEL, 1, 1));
    vecs.push_back(mk("right_of_sprite", 0, 1, 1, 1,  32,   0, BRD, 1, 1));
    vecs.push_back(mk("sprite_corner",   0, 1, 1, 1,  31,  31, YEL, 1, 1));
    vecs.push_back(mk("below_sprite",    0, 1, 1, 1,  31,  32, BG,  1, 1));
    vecs.push_back(mk("background",      0, 1, 1, 1, 100, 100, BG,  1, 1));
    vecs.push_back(mk("blanked",         0, 0, 1, 1, 100, 100, BLK, 1, 1));
    vecs.push_back(mk("blank_over_spr",  0, 0, 1, 1,   0,   0, BLK, 1, 1));
    vecs.push_back(mk("hsync_low",       0, 1, 0, 1, 100, 100, BG,  0, 1));
    vecs.push_back(mk("vsync_low",       0, 1, 1, 0, 100, 100, BG,  1, 0));
    vecs.push_back(mk("corner_639_479",  0, 1, 1, 1, 639, 479, BRD, 1, 1));
    vecs.push_back(mk("left_edge",       0, 1, 1, 1,   1, 200, BRD, 1, 1));
    vecs.push_back(mk("right_edge",      0, 1, 1, 1, 638, 200, BRD, 1, 1));
    vecs.push_back(mk("inside_right",    0, 1, 1, 1, 637, 200, BG,  1, 1));
    vecs.push_back(mk("clr_mid_frame",   1, 1, 0, 0,   0,   0, BLK, 1, 1));
    vecs.push_back(mk("after_clr",       0, 1, 0, 0,   0,   0, YEL, 0, 0));

    clr = 1'b1; video_on = 1'b1; frame_start = 1'b0; pause = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; hcount = 10'd0; vcount = 10'd0;
    tick();
    tick();
    check("reset_state", {red, green, blue, hsync, vsync}, {BLK, 2'b11});

    foreach (vecs[i]) begin
      clr = vecs[i].clr; video_on = vecs[i].von;
      hsync_in = vecs[i].hs; vsync_in = vecs[i].vs;
      hcount = vecs[i].hc; vcount = vecs[i].vc;
      frame_start = 1'b0; pause = 1'b0;
      tick();
      check(vecs[i].name, {red, green, blue, hsync, vsync},
            {vecs[i].rgb, vecs[i].ehs, vecs[i].evs});
    end

    // Sync must change only at the clock edge after its input changes.
    clr = 1'b0; video_on = 1'b1; hcount = 10'd100; vcount = 10'd100;
    for (int i = 0; i < 4; i++) begin
      hsync_in = i[0]; vsync_in = ~i[0];
      tick();
      hsync_in = ~i[0]; vsync_in = i[0];
      #5;
      check("sync_delay", {red, green, blue, hsync, vsync}, {BG, i[0], ~i[0]});
    end

    // One frame step from reset: (2,2).
    pulse(1'b0);
    probe("move_old_1_1",  1,  1, BRD);
    probe("move_new_2_2",  2,  2, YEL);
    probe("move_33_33",   33, 33, YEL);
    probe("move_34_34",   34, 34, BG);

    // clr wins over frame_start on the same edge.
    clr = 1'b1; frame_start = 1'b1; video_on = 1'b0;
    tick();
    frame_start = 1'b0;
    probe("clr_prio_0_0",   0,  0, YEL);
    probe("clr_prio_33_33", 33, 33, BG);

    // Pause holds position.
    pulse(1'b1);
    probe("pause_0_0",   0,  0, YEL);
    probe("pause_32_32", 32, 32, BG);

    // 303 steps from reset: x=606 dx=0, y=290 dy=1.
    for (int k = 0; k < 303; k++) pulse(1'b0);
    probe("pre_right_606",   606, 300, YEL);
    probe("pre_right_605",   605, 300, BG);
    pulse(1'b0);  // x=608 dx=1, y=288
    probe("right_608",  608, 298, YEL);
    probe("right_607",  607, 298, BG);
    probe("right_639",  639, 298, YEL);
    probe("right_y288", 620, 288, YEL);
    probe("right_y287", 620, 287, BG);
    pulse(1'b0);  // x=606, y=286
    probe("back_606",   606, 300, YEL);
    probe("back_639",   639, 300, BRD);
    probe("back_y286",  620, 286, YEL);

    // 302 more steps: x=2 dx=1, y=318 dy=0; next step bounces x to 0.
    for (int k = 0; k < 302; k++) pulse(1'b0);
    probe("pre_left_2",  2, 330, YEL);
    probe("pre_left_1",  1, 330, BRD);
    pulse(1'b0);  // x=0 dx=0, y=320
    probe("left_0",      0, 330, YEL);
    probe("left_31",    31, 351, YEL);
    probe("left_32",    32, 330, BG);
    probe("left_y352",  10, 352, BG);
    pulse(1'b1);
    probe("lpause_0",    0, 330, YEL);
    probe("lpause_y320", 10, 320, YEL);
    probe("lpause_y319", 10, 319, BG);
    pulse(1'b0);  // dx=0 confirmed: x=2, y=322
    probe("after_left_2",  2, 330, YEL);
    probe("after_left_1",  1, 330, BRD);
    probe("after_left_33", 33, 330, YEL);
    probe("after_left_y321", 10, 321, BG);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
